// File: rtl/fcvt_int_wb.sv
// -----------------------------------------------------------------------------
// fcvt_int_wb
//
// Writeback stage behind the float-to-int converter. Each converter result is
// formatted for the integer register file and buffered in a 2-entry FIFO.
// Formatting happens in the enqueue cycle, so the FIFO holds final values and
// the output side is a plain register mux with no path from any in_* port.
// Formatting does two things:
//   - 32-bit results are sign-extended from bit 31 to XLEN. This includes
//     unsigned-word results, which RV64 also sign-extends.
//   - The 3 converter flags are mapped onto the 5 RISC-V fflags bits.
// A sticky accumulator ORs in the fflags of every dequeued entry. The CSR
// logic reads it and can clear it.
//
// Ports
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   in_valid     converter result present
//   in_ready     stage can accept; high whenever fewer than two entries held
//   in_out       converter integer result (INTW bits)
//   in_flags     converter flags {invalid, overflow, inexact}
//   in_word      1 = 32-bit conversion, result in in_out[31:0]
//   in_rd        destination register tag, passed through
//   out_valid    head entry valid
//   out_ready    consumer accepts the head entry
//   out_data     head entry data, XLEN bits
//   out_fflags   head entry fflags {NV,DZ,OF,UF,NX}
//   out_rd       head entry tag
//   acc_fflags   sticky OR of all dequeued fflags
//   acc_clear    clear the accumulator (a same-cycle dequeue is still kept)
// -----------------------------------------------------------------------------
module fcvt_int_wb #(
    parameter int XLEN = 64,
    parameter int INTW = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [INTW-1:0] in_out,
    input  logic [2:0]      in_flags,
    input  logic            in_word,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [4:0]      out_fflags,
    output logic [4:0]      out_rd,
    output logic [4:0]      acc_fflags,
    input  logic            acc_clear
);

    // Sign-extend a word result from bit 31. Full-width results pass through.
    // A loop is used instead of a replication so that XLEN = 32 stays legal.
    function automatic logic [XLEN-1:0] fmt_data(input logic [INTW-1:0] v,
                                                 input logic            word);
        logic [XLEN-1:0] r;
        r = v;
        if (word) begin
            for (int i = 32; i < XLEN; i++) begin
                r[i] = v[31];
            end
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Map {invalid, overflow, inexact} to {NV,DZ,OF,UF,NX}.
    // An out-of-range conversion reports only NV: inexact is masked whenever
    // invalid or overflow is raised. DZ, OF and UF never arise from this
    // conversion.
    function automatic logic [4:0] fmt_flags(input logic [2:0] f);
        logic nv;
        logic nx;
        nv = f[2] | f[1];
        nx = f[0] & ~f[2] & ~f[1];
        return {nv, 1'b0, 1'b0, 1'b0, nx};
    endfunction

    logic [1:0]      count_r;
    logic            rd_ptr_r;
    logic            wr_ptr_r;
    logic [XLEN-1:0] data_r   [2];
    logic [4:0]      fflags_r [2];
    logic [4:0]      rd_r     [2];
    logic [4:0]      acc_r;

    logic            enq_s;
    logic            deq_s;
    logic [1:0]      count_nxt_s;
    logic [4:0]      deq_fflags_s;

    // Handshake flags depend only on registered count, so they are valid at
    // the start of the cycle.
    assign in_ready   = (count_r != 2'd2);
    assign out_valid  = (count_r != 2'd0);
    assign out_data   = data_r[rd_ptr_r];
    assign out_fflags = fflags_r[rd_ptr_r];
    assign out_rd     = rd_r[rd_ptr_r];
    assign acc_fflags = acc_r;

    // Transfer decode and next occupancy.
    always_comb begin
        enq_s        = in_valid & in_ready;
        deq_s        = out_valid & out_ready;
        count_nxt_s  = count_r;
        deq_fflags_s = 5'b00000;
        case ({enq_s, deq_s})
            2'b10:   count_nxt_s = count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
        endcase
        if (deq_s) begin
            deq_fflags_s = fflags_r[rd_ptr_r];
        end else begin
            deq_fflags_s = 5'b00000;
        end
    end

    // Occupancy counter and read/write pointers. One-bit pointers wrap
    // naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r  <= 2'd0;
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            if (enq_s) begin
                wr_ptr_r <= ~wr_ptr_r;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (deq_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Entry storage. Formatted values are written at the write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                data_r[i]   <= '0;
                fflags_r[i] <= 5'b00000;
                rd_r[i]     <= 5'd0;
            end
        end else if (enq_s) begin
            data_r[wr_ptr_r]   <= fmt_data(in_out, in_word);
            fflags_r[wr_ptr_r] <= fmt_flags(in_flags);
            rd_r[wr_ptr_r]     <= in_rd;
        end else begin
            for (int i = 0; i < 2; i++) begin
                data_r[i]   <= data_r[i];
                fflags_r[i] <= fflags_r[i];
                rd_r[i]     <= rd_r[i];
            end
        end
    end

    // Sticky fflags accumulator. A clear wins over the old value but still
    // keeps the flags of the entry leaving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= 5'b00000;
        end else if (acc_clear) begin
            acc_r <= deq_fflags_s;
        end else begin
            acc_r <= acc_r | deq_fflags_s;
        end
    end

endmodule

// File: tb/tb_fcvt_int_wb.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for fcvt_int_wb (XLEN = INTW = 64).
// Inputs are driven 1 time unit after a rising edge. Outputs are checked at
// that same point, which is away from both clock edges.
// -----------------------------------------------------------------------------
module tb_fcvt_int_wb;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_out;
    logic [2:0]  in_flags;
    logic        in_word;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_fflags;
    logic [4:0]  out_rd;
    logic [4:0]  acc_fflags;
    logic        acc_clear;

    int checks = 0;
    int errors = 0;

    logic [2:0] fl_in  [4];
    logic [4:0] fl_exp [4];

    fcvt_int_wb #(.XLEN(64), .INTW(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_out     (in_out),
        .in_flags   (in_flags),
        .in_word    (in_word),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_fflags (out_fflags),
        .out_rd     (out_rd),
        .acc_fflags (acc_fflags),
        .acc_clear  (acc_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        fl_in[0] = 3'b100; fl_exp[0] = 5'b10000;
        fl_in[1] = 3'b011; fl_exp[1] = 5'b10000;
        fl_in[2] = 3'b010; fl_exp[2] = 5'b10000;
        fl_in[3] = 3'b000; fl_exp[3] = 5'b00000;

        rst_n = 1'b0; in_valid = 1'b0; in_out = 64'd0; in_flags = 3'b000;
        in_word = 1'b0; in_rd = 5'd0; out_ready = 1'b0; acc_clear = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // Reset / idle state
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_fflags", 64'(out_fflags), 64'd0);
        chk("rst_out_rd", 64'(out_rd), 64'd0);
        chk("rst_acc", 64'(acc_fflags), 64'd0);

        // Word result is sign-extended from bit 31
        in_valid = 1'b1; in_word = 1'b1; in_out = 64'h0000_0000_8000_0001;
        in_flags = 3'b001; in_rd = 5'd5;
        tick();
        in_valid = 1'b0;
        chk("w_valid", 64'(out_valid), 64'd1);
        chk("w_data", out_data, 64'hFFFF_FFFF_8000_0001);
        chk("w_fflags", 64'(out_fflags), 64'h01);
        chk("w_rd", 64'(out_rd), 64'd5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("w_drained", 64'(out_valid), 64'd0);
        chk("w_acc", 64'(acc_fflags), 64'h01);

        // Full-width result passes through unchanged
        in_valid = 1'b1; in_word = 1'b0; in_out = 64'h0000_0000_8000_0001;
        in_flags = 3'b000; in_rd = 5'd6;
        tick();
        in_valid = 1'b0;
        chk("l_data", out_data, 64'h0000_0000_8000_0001);
        chk("l_fflags", 64'(out_fflags), 64'h00);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Flag mapping
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_flags = fl_in[i]; in_out = 64'(i); in_rd = 5'(i + 8);
            tick();
            in_valid = 1'b0;
            chk("flag_map", 64'(out_fflags), 64'(fl_exp[i]));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        chk("acc_after_map", 64'(acc_fflags), 64'h11);

        // Clear with no dequeue
        acc_clear = 1'b1;
        tick();
        acc_clear = 1'b0;
        chk("acc_clear_idle", 64'(acc_fflags), 64'h00);

        // NX then NV dequeued -> NV|NX
        in_valid = 1'b1; in_flags = 3'b001; in_rd = 5'd20;
        tick();
        in_flags = 3'b100; in_rd = 5'd21;
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("acc_nx", 64'(acc_fflags), 64'h01);
        tick();
        out_ready = 1'b0;
        chk("acc_nx_nv", 64'(acc_fflags), 64'h11);

        // Clear in the same cycle as an NX dequeue keeps that NX
        in_valid = 1'b1; in_flags = 3'b001; in_rd = 5'd22;
        tick();
        in_valid = 1'b0; out_ready = 1'b1; acc_clear = 1'b1;
        tick();
        out_ready = 1'b0; acc_clear = 1'b0;
        chk("acc_clear_deq", 64'(acc_fflags), 64'h01);

        // Backpressure: third input held while full, order preserved
        in_flags = 3'b000; in_word = 1'b0;
        in_valid = 1'b1; in_rd = 5'd1; in_out = 64'd101;
        tick();
        in_rd = 5'd2; in_out = 64'd102;
        tick();
        in_rd = 5'd3; in_out = 64'd103;
        chk("bp_full_ready", 64'(in_ready), 64'd0);
        chk("bp_head_rd", 64'(out_rd), 64'd1);
        tick();
        chk("bp_stall_rd", 64'(out_rd), 64'd1);
        chk("bp_stall_data", out_data, 64'd101);
        out_ready = 1'b1;
        tick();
        chk("bp_out2_rd", 64'(out_rd), 64'd2);
        chk("bp_out2_data", out_data, 64'd102);
        chk("bp_ready_again", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_out3_rd", 64'(out_rd), 64'd3);
        chk("bp_out3_data", out_data, 64'd103);
        tick();
        out_ready = 1'b0;
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Streaming with pointer wrap, one result per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_rd = 5'(i); in_out = 64'(i * 3 + 1);
            tick();
            chk("st_rd", 64'(out_rd), 64'(i));
            chk("st_data", out_data, 64'(i * 3 + 1));
            chk("st_ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("st_empty", 64'(out_valid), 64'd0);

        // Asynchronous reset with two entries buffered
        in_valid = 1'b1; in_rd = 5'd30; in_out = 64'hDEAD; in_flags = 3'b100;
        tick();
        in_rd = 5'd31;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_full", 64'(in_ready), 64'd0);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_ready", 64'(in_ready), 64'd1);
        chk("async_rst_data", out_data, 64'd0);
        chk("async_rst_rd", 64'(out_rd), 64'd0);
        chk("async_rst_acc", 64'(acc_fflags), 64'd0);
        #3 rst_n = 1'b1;
        tick();
        chk("post_rst_valid", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fcvt_int_wb.md
# fcvt_int_wb

Writeback stage directly downstream of the float-to-int converter in the fbox. Accepts each converter result with its 3-bit hardfloat integer exception flags, formats it for the integer register file, and buffers it in a 2-entry FIFO behind a valid/ready handshake. Formatting covers 32-bit result sign-extension to XLEN and mapping to RISC-V 5-bit fflags. Also maintains a sticky fflags accumulator that the CSR logic reads and clears.

## Interface
- XLEN, 64, width of written-back integer data (32 or 64)
- INTW, 64, width of converter result input; INTW == XLEN
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  converter result present
- in_ready  out  1  stage can accept; equals (count != 2)
- in_out  in  INTW  converter integer result
- in_flags  in  3  converter flags {invalid, overflow, inexact}
- in_word  in  1  1 = 32-bit conversion (W/WU); result in in_out[31:0]
- in_rd  in  5  destination register tag, passed through
- out_valid  out  1  head entry valid; equals (count != 0)
- out_ready  in  1  consumer accepts head entry
- out_data  out  XLEN  head entry formatted data
- out_fflags  out  5  head entry fflags {NV,DZ,OF,UF,NX}
- out_rd  out  5  head entry tag
- acc_fflags  out  5  sticky OR of all dequeued fflags
- acc_clear  in  1  clear accumulator

## Operation
- Enqueue when in_valid & in_ready; dequeue when out_valid & out_ready.
- Formatting is applied before storage, in the enqueue cycle:
  - data = in_word ? {{(XLEN-32){in_out[31]}}, in_out[31:0]} : in_out. Sign-extend from bit 31 regardless of signedness; WU results are also sign-extended, per RV64.
  - NV = in_flags[2] | in_flags[1]
  - NX = in_flags[0] & ~in_flags[2] & ~in_flags[1]
  - DZ = OF = UF = 0
- Storage: 2 entries, rd_ptr/wr_ptr 1 bit each (wrap 1->0), count 0..2. Entry fields are data, fflags, rd.
- Outputs present entry[rd_ptr]. Head fields hold stable while out_valid & ~out_ready.
- Simultaneous enq+deq:
  - count 1: count stays 1, both pointers advance.
  - count 2: in_ready = 0, so dequeue only.
  - count 0: dequeue impossible; enqueue only.
- No combinational path from in_* to out_*. No path from out_ready to in_ready.
- Accumulator next value:
  - acc_clear = 1: deq ? out_fflags : 0. Clear takes priority; the same-cycle dequeue is still recorded.
  - acc_clear = 0: acc_fflags | (deq ? out_fflags : 0).
- Reset mid-operation drops all buffered entries immediately and asynchronously. No dequeue is signalled for dropped entries.

## Timing
- Reset values: count=0, pointers=0, storage=0, acc_fflags=0. Therefore out_valid=0, out_data=0, out_fflags=0, out_rd=0, in_ready=1.
- Latency: an entry enqueued at edge N is visible on out_* after edge N; consumable at edge N+1 at the earliest.
- Throughput: 1 result/cycle sustained when out_ready is held high.
- in_ready depends only on registered count, so it is valid at cycle start.
- acc_fflags updates on the edge of the dequeue.

## Test plan
- Reset, then idle: out_valid=0, in_ready=1, out_data=0, acc_fflags=0. Assert rst_n low mid-stream with count=2: out_valid drops without a clock edge.
- Word sign-extension: in_word=1, in_out=0x0000_0000_8000_0001, flags=3'b001 -> out_data=0xFFFF_FFFF_8000_0001, out_fflags=5'b00001 one cycle later. With in_word=0, the same value passes unchanged.
- Flag mapping: flags 3'b100 -> 5'b10000; 3'b011 -> 5'b10000 (NX masked); 3'b010 -> 5'b10000; 3'b000 -> 5'b00000.
- Backpressure: out_ready=0, enqueue rd=1, 2, 3 on consecutive cycles. Third is held because in_ready=0 after two accepts. Raise out_ready: outputs rd 1, 2, then 3 in order, no loss or duplication, head stable while stalled.
- Streaming with wrap: out_ready=1, 10 back-to-back inputs rd=0..9 -> 10 outputs in order, one per cycle, count never exceeds 1, pointers wrap.
- Accumulator: dequeue NX then NV entries -> acc=5'b10001. Assert acc_clear in the cycle an NX entry dequeues -> acc=5'b00001. acc_clear with no dequeue -> 0.
